fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequences the fetch stage: drives the PC register enable, the next-PC mux select and the branch target.
- Handshakes with a variable-latency instruction memory using req/ack.
- Applies decode-stage stalls and branch redirects from the memory stage.
- Guarantees that an in-flight fetch completes before the PC is redirected, and that the result of such a fetch is discarded.

Parameters:
- N, 64, PC / address width.
- CNT_W, 32, width of the performance counters (only used when the optional feature is compiled in).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- branch_taken_M  in  1  redirect request from the memory stage.
- branch_target_M  in  N  redirect target; valid when branch_taken_M=1.
- stall_D  in  1  decode stage cannot accept an instruction this cycle.
- imem_ack  in  1  instruction memory completes the current access this cycle.
- imem_req  out  1  fetch request at the current PC.
- pc_enable  out  1  PC register enable (fetch enable).
- pc_src  out  1  next-PC select: 0 = PC+4, 1 = pc_branch.
- pc_branch  out  N  redirect target presented to the PC mux.
- instr_valid_D  out  1  fetched instruction is written to IF/ID as valid.
- flush_D  out  1  invalidate IF/ID contents.

Behaviour:
- State machine: BOOT, FETCH, DRAIN. Registers: state and redirect_q[N-1:0].
- Outputs are combinational from state and inputs.
- Reset (asynchronous, any cycle, including mid-access):
  - state=BOOT, redirect_q=0.
  - All outputs are 0; pc_branch=0.
- BOOT:
  - Lasts exactly one cycle after reset deasserts.
  - imem_req=0, pc_enable=0. Next state is FETCH.
- FETCH: imem_req=1. Priority order:
  1. branch_taken_M=1 and imem_ack=1: pc_enable=1, pc_src=1, pc_branch=branch_target_M, flush_D=1, instr_valid_D=0. Stay in FETCH.
  2. branch_taken_M=1 and imem_ack=0: redirect_q<=branch_target_M, flush_D=1, pc_enable=0. Go to DRAIN.
  3. imem_ack=1 and stall_D=0: pc_enable=1, pc_src=0, instr_valid_D=1.
  4. imem_ack=1 and stall_D=1: pc_enable=0, instr_valid_D=0. The instruction is dropped and re-fetched at the same PC.
  5. imem_ack=0: pc_enable=0, instr_valid_D=0. imem_req stays high.
- DRAIN:
  - imem_req=1 and instr_valid_D=0.
  - branch_taken_M=1 overwrites redirect_q with branch_target_M and asserts flush_D=1. The newest target wins.
  - On imem_ack=1:
    - pc_enable=1, pc_src=1.
    - pc_branch = (branch_taken_M ? branch_target_M : redirect_q).
    - Go to FETCH.
  - stall_D is ignored in DRAIN.
- pc_branch equals redirect_q whenever no redirect is being applied.
- Handshake rule: once imem_req=1, it stays high until imem_ack=1. The PC never changes while an access is outstanding.
- imem_ack while imem_req=0 (in BOOT) is ignored.
- Throughput: with imem_ack tied to 1 and no stalls, one instruction per cycle, starting in the second cycle after reset release.
- Redirect latency:
  - Zero-wait memory: the target is in the PC at the next edge.
  - Otherwise: the target enters the PC at the edge following the outstanding ack.

Optional Feature:
- Macro: FETCH_CTRL_PERF_EN.
- When defined, adds three CNT_W-bit outputs, reset to 0, each wrapping at 2^CNT_W:
  - perf_fetch_cnt: counts cycles with instr_valid_D=1.
  - perf_stall_cnt: counts cycles with imem_req=1 and pc_enable=0.
  - perf_redirect_cnt: counts cycles with pc_enable=1 and pc_src=1.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset low 3 cycles, release, imem_ack=1 constant -> cycle 1 after release: imem_req=0; from cycle 2: pc_enable=1, pc_src=0, instr_valid_D=1 every cycle.
- FETCH, imem_ack=1, stall_D=1 for 2 cycles -> pc_enable=0 and instr_valid_D=0 for 2 cycles, then resume with pc_enable=1.
- FETCH, imem_ack=0, branch_taken_M=1, target=0x40, then ack 3 cycles later:
  - flush_D=1 in the branch cycle and state=DRAIN.
  - In the ack cycle: pc_enable=1, pc_src=1, pc_branch=0x40.
  - instr_valid_D=0 throughout.
- In DRAIN (target 0x40), second branch_taken_M with target 0x80 before ack -> redirect applied on ack with pc_branch=0x80.
- Branch and imem_ack in the same FETCH cycle, target 0x100 -> pc_enable=1, pc_src=1, pc_branch=0x100, flush_D=1, instr_valid_D=0, state stays FETCH.
- Reset asserted mid-DRAIN -> immediate BOOT, all outputs 0; redirect_q cleared (pc_branch=0 after release). With FETCH_CTRL_PERF_EN defined, all counters read 0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: PC enable/select, imem req/ack handshake, stall and redirect handling.
// Optional performance counters are compiled in with `define FETCH_CTRL_PERF_EN.
module fetch_ctrl #(
  parameter int unsigned N     = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         branch_taken_M,
  input  logic [N-1:0] branch_target_M,
  input  logic         stall_D,
  input  logic         imem_ack,
  output logic         imem_req,
  output logic         pc_enable,
  output logic         pc_src,
  output logic [N-1:0] pc_branch,
  output logic         instr_valid_D,
  output logic         flush_D
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_fetch_cnt,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_redirect_cnt
`endif
);

  typedef enum logic [1:0] {StBoot, StFetch, StDrain} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   redirect_q, redirect_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StBoot;
      redirect_q <= '0;
    end else begin
      state_q    <= state_d;
      redirect_q <= redirect_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    redirect_d    = redirect_q;
    imem_req      = 1'b0;
    pc_enable     = 1'b0;
    pc_src        = 1'b0;
    pc_branch     = redirect_q;
    instr_valid_D = 1'b0;
    flush_D       = 1'b0;
    unique case (state_q)
      StBoot: state_d = StFetch;
      StFetch: begin
        imem_req = 1'b1;
        if (branch_taken_M) begin
          flush_D = 1'b1;
          if (imem_ack) begin
            pc_enable = 1'b1;
            pc_src    = 1'b1;
            pc_branch = branch_target_M;
          end else begin
            // Access still outstanding: park the target until the ack arrives.
            redirect_d = branch_target_M;
            state_d    = StDrain;
          end
        end else if (imem_ack && !stall_D) begin
          pc_enable     = 1'b1;
          instr_valid_D = 1'b1;
        end
      end
      StDrain: begin
        imem_req = 1'b1;
        if (branch_taken_M) begin
          flush_D    = 1'b1;
          redirect_d = branch_target_M;
        end
        // The draining fetch result is discarded; only the redirect is applied.
        if (imem_ack) begin
          pc_enable = 1'b1;
          pc_src    = 1'b1;
          pc_branch = branch_taken_M ? branch_target_M : redirect_q;
          state_d   = StFetch;
        end
      end
      default: state_d = StBoot;
    endcase
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [CNT_W-1:0] fetch_cnt_q, stall_cnt_q, redirect_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt_q    <= '0;
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if (instr_valid_D)         fetch_cnt_q    <= fetch_cnt_q + CNT_W'(1);
      if (imem_req && !pc_enable) stall_cnt_q   <= stall_cnt_q + CNT_W'(1);
      if (pc_enable && pc_src)   redirect_cnt_q <= redirect_cnt_q + CNT_W'(1);
    end
  end

  assign perf_fetch_cnt    = fetch_cnt_q;
  assign perf_stall_cnt    = stall_cnt_q;
  assign perf_redirect_cnt = redirect_cnt_q;
`else
  logic [31:0] unused_cnt_w;
  assign unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, async-reset sequence,
// and randomized traffic checked against a PC-level reference model.
module tb_fetch_ctrl;
  localparam int unsigned N     = 64;
  localparam int unsigned CNT_W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         branch_taken_M = 1'b0;
  logic [N-1:0] branch_target_M = '0;
  logic         stall_D = 1'b0;
  logic         imem_ack = 1'b0;
  logic         imem_req, pc_enable, pc_src, instr_valid_D, flush_D;
  logic [N-1:0] pc_branch;
`ifdef FETCH_CTRL_PERF_EN
  logic [CNT_W-1:0] perf_fetch_cnt, perf_stall_cnt, perf_redirect_cnt;
`endif

  fetch_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .branch_taken_M  (branch_taken_M),
    .branch_target_M (branch_target_M),
    .stall_D         (stall_D),
    .imem_ack        (imem_ack),
    .imem_req        (imem_req),
    .pc_enable       (pc_enable),
    .pc_src          (pc_src),
    .pc_branch       (pc_branch),
    .instr_valid_D   (instr_valid_D),
    .flush_D         (flush_D)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_fetch_cnt    (perf_fetch_cnt),
    .perf_stall_cnt    (perf_stall_cnt),
    .perf_redirect_cnt (perf_redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Output packing: {imem_req, pc_enable, pc_src, instr_valid_D, flush_D, pc_branch}
  typedef logic [N+4:0] outs_t;

  typedef struct {
    logic         br;
    logic [N-1:0] tg;
    logic         st;
    logic         ak;
    outs_t        exp;
    string        name;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference model state, expressed as "has the first cycle passed", "is a redirect
  // waiting on an outstanding access", the parked target, the PC and event counts.
  bit           m_booted;
  bit           m_pending;
  logic [N-1:0] m_rq;
  logic [N-1:0] m_pc;
  logic [N-1:0] d_pc;
  logic [31:0]  m_fc, m_sc, m_rc;

  function automatic vec_t mk(logic br, logic [N-1:0] tg, logic st, logic ak, logic req,
                              logic pe, logic src, logic iv, logic fl, logic [N-1:0] pcb,
                              string name);
    vec_t v;
    v.br = br; v.tg = tg; v.st = st; v.ak = ak;
    v.exp = {req, pe, src, iv, fl, pcb};
    v.name = name;
    return v;
  endfunction

  function automatic outs_t dut_out();
    return {imem_req, pc_enable, pc_src, instr_valid_D, flush_D, pc_branch};
  endfunction

  task automatic check(string name, outs_t got, outs_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic drive(logic br, logic [N-1:0] tg, logic st, logic ak);
    branch_taken_M  = br;
    branch_target_M = tg;
    stall_D         = st;
    imem_ack        = ak;
  endtask

  task automatic model_reset();
    m_booted = 0; m_pending = 0; m_rq = '0; m_pc = '0; d_pc = '0;
    m_fc = 0; m_sc = 0; m_rc = 0;
  endtask

  task automatic model_out(logic br, logic [N-1:0] tg, logic st, logic ak, output outs_t o);
    logic req, pe, src, iv, fl;
    logic [N-1:0] pcb;
    req = 0; pe = 0; src = 0; iv = 0; fl = 0; pcb = m_rq;
    if (m_booted) begin
      req = 1;
      if (m_pending) begin
        fl = br;
        if (ak) begin pe = 1; src = 1; pcb = br ? tg : m_rq; end
      end else if (br) begin
        fl = 1;
        if (ak) begin pe = 1; src = 1; pcb = tg; end
      end else if (ak && !st) begin
        pe = 1; iv = 1;
      end
    end
    o = {req, pe, src, iv, fl, pcb};
  endtask

  task automatic model_step(logic br, logic [N-1:0] tg, logic st, logic ak, outs_t o);
    m_fc += {31'd0, o[N+1]};
    m_sc += {31'd0, o[N+4] & ~o[N+3]};
    m_rc += {31'd0, o[N+3] & o[N+2]};
    if (!m_booted) begin
      m_booted = 1;
    end else if (m_pending) begin
      if (ak) begin
        m_pc = br ? tg : m_rq;
        m_pending = 0;
      end
      if (br) m_rq = tg;
    end else if (br) begin
      if (ak) m_pc = tg;
      else begin m_rq = tg; m_pending = 1; end
    end else if (ak && !st) begin
      m_pc = m_pc + 64'd4;
    end
  endtask

  vec_t tbl[$];
  outs_t exp_o;
  logic         rb, rs, ra;
  logic [N-1:0] rt;

  initial begin
    tbl.push_back(mk(0, 64'h0,   0, 1, 0, 0, 0, 0, 0, 64'h0,   "boot_ack_ignored"));
    tbl.push_back(mk(0, 64'h0,   0, 1, 1, 1, 0, 1, 0, 64'h0,   "stream0"));
    tbl.push_back(mk(0, 64'h0,   0, 1, 1, 1, 0, 1, 0, 64'h0,   "stream1"));
    tbl.push_back(mk(0, 64'h0,   1, 1, 1, 0, 0, 0, 0, 64'h0,   "stall0"));
    tbl.push_back(mk(0, 64'h0,   1, 1, 1, 0, 0, 0, 0, 64'h0,   "stall1"));
    tbl.push_back(mk(0, 64'h0,   0, 1, 1, 1, 0, 1, 0, 64'h0,   "resume"));
    tbl.push_back(mk(1, 64'h40,  0, 0, 1, 0, 0, 0, 1, 64'h0,   "br_no_ack"));
    tbl.push_back(mk(0, 64'h0,   0, 0, 1, 0, 0, 0, 0, 64'h40,  "drain_wait1"));
    tbl.push_back(mk(0, 64'h0,   1, 0, 1, 0, 0, 0, 0, 64'h40,  "drain_wait2"));
    tbl.push_back(mk(0, 64'h0,   1, 1, 1, 1, 1, 0, 0, 64'h40,  "drain_ack"));
    tbl.push_back(mk(1, 64'h40,  0, 0, 1, 0, 0, 0, 1, 64'h40,  "br2_no_ack"));
    tbl.push_back(mk(1, 64'h80,  0, 0, 1, 0, 0, 0, 1, 64'h40,  "drain_rebranch"));
    tbl.push_back(mk(0, 64'h0,   0, 1, 1, 1, 1, 0, 0, 64'h80,  "newest_wins"));
    tbl.push_back(mk(1, 64'h100, 0, 1, 1, 1, 1, 0, 1, 64'h100, "br_with_ack"));
    tbl.push_back(mk(0, 64'h0,   0, 1, 1, 1, 0, 1, 0, 64'h80,  "after_br_ack"));
    tbl.push_back(mk(1, 64'h200, 0, 0, 1, 0, 0, 0, 1, 64'h80,  "br3_no_ack"));
    tbl.push_back(mk(1, 64'h300, 0, 1, 1, 1, 1, 0, 1, 64'h300, "drain_br_and_ack"));
    tbl.push_back(mk(0, 64'h0,   0, 1, 1, 1, 0, 1, 0, 64'h300, "post_drain"));
    tbl.push_back(mk(0, 64'h0,   0, 0, 1, 0, 0, 0, 0, 64'h300, "fetch_wait"));
    tbl.push_back(mk(1, 64'h500, 0, 0, 1, 0, 0, 0, 1, 64'h300, "br4_no_ack"));

    // Reset held for 3 cycles, released just after a rising edge.
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].br, tbl[i].tg, tbl[i].st, tbl[i].ak);
      #1 check(tbl[i].name, dut_out(), tbl[i].exp);
    end

    // Now in DRAIN with target 0x500 parked; reset asynchronously mid-access.
    @(negedge clk);
    drive(0, 64'h0, 0, 0);
    #1 check("drain_before_reset", dut_out(), {5'b10000, 64'h500});
    #2 reset = 1'b0;
    #1 check("async_reset_outs", dut_out(), '0);
`ifdef FETCH_CTRL_PERF_EN
    check("perf_fetch_rst", outs_t'(perf_fetch_cnt), '0);
    check("perf_stall_rst", outs_t'(perf_stall_cnt), '0);
    check("perf_redirect_rst", outs_t'(perf_redirect_cnt), '0);
`endif
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    drive(0, 64'h0, 0, 1);
    #1 check("boot_after_reset", dut_out(), '0);
    @(negedge clk);
    drive(0, 64'h0, 0, 0);
    #1 check("redirect_cleared", dut_out(), {5'b10000, 64'h0});

    // Randomized traffic against the reference model.
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rb = ($urandom_range(0, 4) == 0);
      rt = {$urandom, $urandom} & ~64'h3;
      rs = ($urandom_range(0, 3) == 0);
      ra = ((i % 400) < 150) ? 1'b1 : ($urandom_range(0, 2) == 0);
      drive(rb, rt, rs, ra);
      #1;
      model_out(rb, rt, rs, ra, exp_o);
      check("rand_outputs", dut_out(), exp_o);
      check("rand_pc", outs_t'(d_pc), outs_t'(m_pc));
      if (pc_enable) d_pc = pc_src ? pc_branch : d_pc + 64'd4;
      model_step(rb, rt, rs, ra, exp_o);
    end
    @(negedge clk);
    check("rand_pc_final", outs_t'(d_pc), outs_t'(m_pc));
`ifdef FETCH_CTRL_PERF_EN
    check("perf_fetch", outs_t'(perf_fetch_cnt), outs_t'(m_fc));
    check("perf_stall", outs_t'(perf_stall_cnt), outs_t'(m_sc));
    check("perf_redirect", outs_t'(perf_redirect_cnt), outs_t'(m_rc));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
